// File: rtl/npu_dma_copy_engine_if.sv
// rtl/npu_dma_copy_engine_if.sv - AXI4 master bundle between the DMA copy engine and memory
interface npu_dma_copy_engine_if #(
  parameter int DATA_W = 256
);
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [63:0]       m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic              m_axi_rlast;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [63:0]       m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic              m_axi_wlast;
  logic              m_axi_bvalid;
  logic              m_axi_bready;

  modport master (
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata, m_axi_rlast,
    output m_axi_rready,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    input  m_axi_wready,
    input  m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata, m_axi_rlast,
    input  m_axi_rready,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    output m_axi_wready,
    output m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/npu_dma_copy_engine.sv
// rtl/npu_dma_copy_engine.sv - store-and-forward AXI4 copy engine for the NPU DMA port
// Optional NPU_DMA_4K_SPLIT_EN keeps every burst inside one 4 KB page on src and dst.
module npu_dma_copy_engine #(
  parameter int MAX_BURST = 16,
  parameter int DATA_W    = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_req_valid,
  output logic        dma_req_ready,
  input  logic [63:0] dma_req_src,
  input  logic [63:0] dma_req_dst,
  input  logic [31:0] dma_req_bytes,
  output logic        dma_resp_done,
  output logic        busy,
  npu_dma_copy_engine_if.master axi
);
  localparam int IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              out_en_q;
  logic [63:0]       src_q, dst_q;
  logic [27:0]       rem_q;
  logic [4:0]        tail_q;
  logic [IDX_W-1:0]  idx_q;
  logic [8:0]        lim, chunk;
  logic              last_beat, final_chunk;
  logic [DATA_W-1:0] beat_buf [MAX_BURST];

`ifdef NPU_DMA_4K_SPLIT_EN
  logic [8:0] src_room, dst_room;
`endif

  always_comb begin
    lim = 9'(MAX_BURST);
`ifdef NPU_DMA_4K_SPLIT_EN
    src_room = 9'd128 - {2'b00, src_q[11:5]};
    dst_room = 9'd128 - {2'b00, dst_q[11:5]};
    if (src_room < lim) lim = src_room;
    if (dst_room < lim) lim = dst_room;
`endif
    chunk = (rem_q < {19'd0, lim}) ? rem_q[8:0] : lim;
  end

  assign last_beat   = ({{(9-IDX_W){1'b0}}, idx_q} == (chunk - 9'd1));
  assign final_chunk = (rem_q == {19'd0, chunk});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Payloads are forced to zero outside their channel state so reset leaves every output low.
  always_comb begin
    state_d           = state_q;
    dma_req_ready     = 1'b0;
    dma_resp_done     = 1'b0;
    busy              = (state_q != S_IDLE);
    axi.m_axi_arvalid = 1'b0;
    axi.m_axi_araddr  = '0;
    axi.m_axi_arlen   = '0;
    axi.m_axi_arsize  = '0;
    axi.m_axi_rready  = 1'b0;
    axi.m_axi_awvalid = 1'b0;
    axi.m_axi_awaddr  = '0;
    axi.m_axi_awlen   = '0;
    axi.m_axi_awsize  = '0;
    axi.m_axi_wvalid  = 1'b0;
    axi.m_axi_wdata   = '0;
    axi.m_axi_wstrb   = '0;
    axi.m_axi_wlast   = 1'b0;
    axi.m_axi_bready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        dma_req_ready = out_en_q;
        if (dma_req_valid && out_en_q)
          state_d = (dma_req_bytes == 32'd0) ? S_DONE : S_AR;
      end
      S_AR: begin
        axi.m_axi_arvalid = 1'b1;
        axi.m_axi_araddr  = src_q;
        axi.m_axi_arlen   = 8'(chunk - 9'd1);
        axi.m_axi_arsize  = 3'd5;
        if (axi.m_axi_arready) state_d = S_R;
      end
      S_R: begin
        axi.m_axi_rready = 1'b1;
        if (axi.m_axi_rvalid && last_beat) state_d = S_AW;
      end
      S_AW: begin
        axi.m_axi_awvalid = 1'b1;
        axi.m_axi_awaddr  = dst_q;
        axi.m_axi_awlen   = 8'(chunk - 9'd1);
        axi.m_axi_awsize  = 3'd5;
        if (axi.m_axi_awready) state_d = S_W;
      end
      S_W: begin
        axi.m_axi_wvalid = 1'b1;
        axi.m_axi_wdata  = beat_buf[idx_q];
        axi.m_axi_wlast  = last_beat;
        axi.m_axi_wstrb  = (final_chunk && last_beat && tail_q != 5'd0) ?
                           ((32'h1 << tail_q) - 32'h1) : '1;
        if (axi.m_axi_wready && last_beat) state_d = S_B;
      end
      S_B: begin
        axi.m_axi_bready = 1'b1;
        if (axi.m_axi_bvalid) state_d = final_chunk ? S_DONE : S_AR;
      end
      S_DONE: begin
        dma_resp_done = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // out_en_q holds dma_req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en_q <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      tail_q   <= '0;
      idx_q    <= '0;
    end else begin
      out_en_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (dma_req_valid && out_en_q) begin
            src_q  <= {dma_req_src[63:5], 5'd0};
            dst_q  <= {dma_req_dst[63:5], 5'd0};
            rem_q  <= {1'b0, dma_req_bytes[31:5]} + {27'd0, |dma_req_bytes[4:0]};
            tail_q <= dma_req_bytes[4:0];
            idx_q  <= '0;
          end
        end
        S_R: if (axi.m_axi_rvalid) idx_q <= last_beat ? '0 : idx_q + IDX_ONE;
        S_W: if (axi.m_axi_wready) idx_q <= last_beat ? '0 : idx_q + IDX_ONE;
        S_B: begin
          if (axi.m_axi_bvalid) begin
            src_q <= src_q + {50'd0, chunk, 5'd0};
            dst_q <= dst_q + {50'd0, chunk, 5'd0};
            rem_q <= rem_q - {19'd0, chunk};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_R && axi.m_axi_rvalid) beat_buf[idx_q] <= axi.m_axi_rdata;
  end
endmodule

// File: tb/tb_npu_dma_copy_engine.sv
// tb/tb_npu_dma_copy_engine.sv - directed self-checking bench with a burst/memory model for the DMA copy engine
`timescale 1ns/1ps
module tb_npu_dma_copy_engine;
  localparam int MB    = 16;
  localparam int MEMSZ = 16384;

  typedef struct packed { logic [63:0] addr; logic [7:0] len; } burst_t;
  typedef struct packed { logic [255:0] data; logic [31:0] strb; logic last; } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dma_req_valid = 1'b0;
  logic [63:0] dma_req_src = '0;
  logic [63:0] dma_req_dst = '0;
  logic [31:0] dma_req_bytes = '0;
  logic        dma_req_ready, dma_resp_done, busy;

  always #5 clk = ~clk;

  npu_dma_copy_engine_if axi();

  npu_dma_copy_engine #(.MAX_BURST(MB), .DATA_W(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
    .dma_req_src(dma_req_src), .dma_req_dst(dma_req_dst), .dma_req_bytes(dma_req_bytes),
    .dma_resp_done(dma_resp_done), .busy(busy), .axi(axi)
  );

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, acc_cnt = 0, acc_cyc = 0, done_cyc = 0, valid_seen = 0, aw_open = 0;
  logic bp = 1'b0;
  logic [31:0] last_wstrb = '0;
  logic [7:0] mem [MEMSZ];
  logic [7:0] exp_mem [MEMSZ];
  burst_t ar_exp[$], aw_exp[$], ar_obs[$];
  beat_t  w_exp[$];

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial forever begin @(posedge clk); cyc++; end

  // Reference: split the command into bursts and beats straight from the copy rules.
  task automatic build_model(input logic [63:0] src, input logic [63:0] dst, input logic [31:0] bytes);
    logic [63:0] rem, s, d, beat_no;
    int chunk, nb, idx;
    burst_t b;
    beat_t  bt;
    ar_exp.delete(); aw_exp.delete(); w_exp.delete(); ar_obs.delete();
    rem = ({32'd0, bytes} + 64'd31) / 64'd32;
    s = src & ~64'h1f;
    d = dst & ~64'h1f;
    beat_no = 0;
    while (rem != 0) begin
      chunk = (rem > 64'(MB)) ? MB : int'(rem);
`ifdef NPU_DMA_4K_SPLIT_EN
      if ((4096 - int'(s[11:0])) / 32 < chunk) chunk = (4096 - int'(s[11:0])) / 32;
      if ((4096 - int'(d[11:0])) / 32 < chunk) chunk = (4096 - int'(d[11:0])) / 32;
`endif
      b.addr = s; b.len = 8'(chunk - 1); ar_exp.push_back(b);
      b.addr = d; aw_exp.push_back(b);
      for (int k = 0; k < chunk; k++) begin
        nb = int'(bytes) - 32 * int'(beat_no);
        if (nb > 32) nb = 32;
        for (int j = 0; j < 32; j++) begin
          idx = (int'(s[13:0]) + 32 * k + j) % MEMSZ;
          bt.data[8*j +: 8] = mem[idx];
          bt.strb[j] = (j < nb);
        end
        bt.last = (k == chunk - 1);
        w_exp.push_back(bt);
        beat_no++;
      end
      s = s + 64'(chunk * 32);
      d = d + 64'(chunk * 32);
      rem = rem - 64'(chunk);
    end
    for (int i = 0; i < MEMSZ; i++) exp_mem[i] = mem[i];
    for (int i = 0; i < int'(bytes); i++)
      exp_mem[(int'(dst[13:0] & 14'h3fe0) + i) % MEMSZ] = mem[(int'(src[13:0] & 14'h3fe0) + i) % MEMSZ];
  endtask

  task automatic init_mem(input logic [63:0] src, input logic [31:0] bytes);
    int base = int'(src[13:0] & 14'h3fe0);
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'h5a;
    for (int i = 0; i < int'(bytes) + 32; i++) mem[(base + i) % MEMSZ] = 8'((base + i) % 256);
  endtask

  // Memory slave: samples handshakes at the edge, drives new values 1 ns later.
  initial begin
    burst_t rq[$], wq[$];
    int r_beat, w_beat, b_pend, idx;
    logic hs_ar, hs_r, hs_aw, hs_w, hs_b, w_l;
    logic [63:0] ar_a, aw_a;
    logic [7:0] ar_l, aw_l;
    logic [255:0] w_d, rd;
    logic [31:0] w_s;
    burst_t b;
    r_beat = 0; w_beat = 0; b_pend = 0;
    axi.m_axi_arready = 0; axi.m_axi_rvalid = 0; axi.m_axi_rdata = '0; axi.m_axi_rlast = 0;
    axi.m_axi_awready = 0; axi.m_axi_wready = 0; axi.m_axi_bvalid = 0;
    forever begin
      @(posedge clk);
      hs_ar = axi.m_axi_arvalid && axi.m_axi_arready; ar_a = axi.m_axi_araddr; ar_l = axi.m_axi_arlen;
      hs_aw = axi.m_axi_awvalid && axi.m_axi_awready; aw_a = axi.m_axi_awaddr; aw_l = axi.m_axi_awlen;
      hs_r  = axi.m_axi_rvalid && axi.m_axi_rready;
      hs_w  = axi.m_axi_wvalid && axi.m_axi_wready;
      w_d = axi.m_axi_wdata; w_s = axi.m_axi_wstrb; w_l = axi.m_axi_wlast;
      hs_b  = axi.m_axi_bvalid && axi.m_axi_bready;
      #1;
      if (!rst_n) begin
        rq.delete(); wq.delete(); r_beat = 0; w_beat = 0; b_pend = 0;
        axi.m_axi_arready = 0; axi.m_axi_rvalid = 0; axi.m_axi_rlast = 0;
        axi.m_axi_awready = 0; axi.m_axi_wready = 0; axi.m_axi_bvalid = 0;
        continue;
      end
      if (hs_ar) begin b.addr = ar_a; b.len = ar_l; rq.push_back(b); end
      if (hs_aw) begin b.addr = aw_a; b.len = aw_l; wq.push_back(b); end
      if (hs_r && rq.size() > 0) begin
        r_beat++;
        if (r_beat > int'(rq[0].len)) begin void'(rq.pop_front()); r_beat = 0; end
      end
      if (hs_w && wq.size() > 0) begin
        for (int j = 0; j < 32; j++) begin
          idx = (int'(wq[0].addr[13:0]) + 32 * w_beat + j) % MEMSZ;
          if (w_s[j]) mem[idx] = w_d[8*j +: 8];
        end
        w_beat++;
        if (w_l) begin void'(wq.pop_front()); w_beat = 0; b_pend++; end
      end
      if (hs_b) b_pend--;
      axi.m_axi_arready = bp ? ($urandom_range(0, 3) == 0) : 1'b1;
      axi.m_axi_awready = bp ? ($urandom_range(0, 3) == 0) : 1'b1;
      axi.m_axi_wready  = bp ? ($urandom_range(0, 3) == 0) : 1'b1;
      if (!(axi.m_axi_rvalid && !hs_r)) begin
        axi.m_axi_rvalid = (rq.size() > 0) && (!bp || $urandom_range(0, 2) == 0);
        if (axi.m_axi_rvalid) begin
          for (int j = 0; j < 32; j++)
            rd[8*j +: 8] = mem[(int'(rq[0].addr[13:0]) + 32 * r_beat + j) % MEMSZ];
          axi.m_axi_rdata = rd;
          axi.m_axi_rlast = (r_beat == int'(rq[0].len));
        end
      end
      if (!(axi.m_axi_bvalid && !hs_b))
        axi.m_axi_bvalid = (b_pend > 0) && (!bp || $urandom_range(0, 3) == 0);
    end
  end

  // Compare process: protocol stability and every handshake against the model.
  initial begin
    logic p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_wl = 0;
    logic [63:0] p_ara = '0, p_awa = '0;
    logic [7:0] p_arl = '0, p_awl = '0;
    logic [255:0] p_wd = '0;
    logic [31:0] p_ws = '0;
    burst_t b;
    beat_t bt;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_ctrl_outputs",
            {dma_req_ready, dma_resp_done, busy, axi.m_axi_arvalid, axi.m_axi_araddr, axi.m_axi_arlen,
             axi.m_axi_arsize, axi.m_axi_rready, axi.m_axi_awvalid, axi.m_axi_awaddr, axi.m_axi_awlen,
             axi.m_axi_awsize, axi.m_axi_wvalid, axi.m_axi_wstrb, axi.m_axi_wlast, axi.m_axi_bready}, '0);
        chk("reset_wdata", axi.m_axi_wdata, '0);
        p_arv = 0; p_awv = 0; p_wv = 0; aw_open = 0;
        continue;
      end
      if (p_arv && !p_arr)
        chk("ar_stable", {axi.m_axi_arvalid, axi.m_axi_araddr, axi.m_axi_arlen}, {1'b1, p_ara, p_arl});
      if (p_awv && !p_awr)
        chk("aw_stable", {axi.m_axi_awvalid, axi.m_axi_awaddr, axi.m_axi_awlen}, {1'b1, p_awa, p_awl});
      if (p_wv && !p_wr)
        chk("w_stable", {axi.m_axi_wvalid, axi.m_axi_wdata, axi.m_axi_wstrb, axi.m_axi_wlast},
            {1'b1, p_wd, p_ws, p_wl});
      if (axi.m_axi_wvalid) chk("w_after_aw", aw_open > 0, 1'b1);
      if (axi.m_axi_arvalid && axi.m_axi_arready) begin
        b.addr = axi.m_axi_araddr; b.len = axi.m_axi_arlen; ar_obs.push_back(b);
        chk("ar_expected", ar_exp.size() > 0, 1'b1);
        if (ar_exp.size() > 0) begin
          b = ar_exp.pop_front();
          chk("ar_burst", {axi.m_axi_araddr, axi.m_axi_arlen, axi.m_axi_arsize}, {b.addr, b.len, 3'd5});
        end
      end
      if (axi.m_axi_awvalid && axi.m_axi_awready) begin
        aw_open++;
        chk("aw_expected", aw_exp.size() > 0, 1'b1);
        if (aw_exp.size() > 0) begin
          b = aw_exp.pop_front();
          chk("aw_burst", {axi.m_axi_awaddr, axi.m_axi_awlen, axi.m_axi_awsize}, {b.addr, b.len, 3'd5});
        end
      end
      if (axi.m_axi_wvalid && axi.m_axi_wready) begin
        last_wstrb = axi.m_axi_wstrb;
        chk("w_expected", w_exp.size() > 0, 1'b1);
        if (w_exp.size() > 0) begin
          bt = w_exp.pop_front();
          chk("w_beat", {axi.m_axi_wdata, axi.m_axi_wstrb, axi.m_axi_wlast}, {bt.data, bt.strb, bt.last});
        end
        if (axi.m_axi_wlast) aw_open--;
      end
      if (axi.m_axi_arvalid || axi.m_axi_awvalid || axi.m_axi_wvalid) valid_seen++;
      if (dma_req_valid && dma_req_ready) begin acc_cnt++; acc_cyc = cyc; end
      if (dma_resp_done) begin done_cnt++; done_cyc = cyc; end
      p_arv = axi.m_axi_arvalid; p_arr = axi.m_axi_arready; p_ara = axi.m_axi_araddr; p_arl = axi.m_axi_arlen;
      p_awv = axi.m_axi_awvalid; p_awr = axi.m_axi_awready; p_awa = axi.m_axi_awaddr; p_awl = axi.m_axi_awlen;
      p_wv = axi.m_axi_wvalid; p_wr = axi.m_axi_wready; p_wd = axi.m_axi_wdata; p_ws = axi.m_axi_wstrb;
      p_wl = axi.m_axi_wlast;
    end
  end

  task automatic issue(input logic [63:0] src, input logic [63:0] dst, input logic [31:0] bytes, input int hold);
    int n = 0;
    init_mem(src, bytes);
    build_model(src, dst, bytes);
    @(posedge clk); #1;
    dma_req_valid = 1'b1; dma_req_src = src; dma_req_dst = dst; dma_req_bytes = bytes;
    do begin @(negedge clk); n++; end while (!dma_req_ready && n < 50);
    chk("accept_timeout", dma_req_ready, 1'b1);
    @(posedge clk); #1;
    if (hold > 0) begin
      dma_req_src = 64'h40; dma_req_bytes = 32'd64;
      repeat (hold) @(posedge clk);
      #1;
    end
    dma_req_valid = 1'b0;
  endtask

  task automatic run_copy(input logic [63:0] src, input logic [63:0] dst, input logic [31:0] bytes, input int hold);
    int d0, a0, n, bad;
    d0 = done_cnt; a0 = acc_cnt;
    issue(src, dst, bytes, hold);
    n = 0;
    while (done_cnt == d0 && n < 3000) begin @(negedge clk); n++; end
    chk("done_timeout", done_cnt > d0, 1'b1);
    @(negedge clk);
    chk("ready_after_done", dma_req_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("accept_once", acc_cnt - a0, 1);
    chk("model_drained", ar_exp.size() + aw_exp.size() + w_exp.size(), 0);
    bad = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk("mem_image", bad, 0);
  endtask

  initial begin
    int v0, d0, n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_low_before_first_edge", dma_req_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_reset", {dma_req_ready, busy, dma_resp_done}, 3'b100);

    run_copy(64'h0, 64'h100, 32'd32, 0);
    chk("single_ar_count", ar_obs.size(), 1);
    chk("single_arlen", ar_obs[0].len, 8'd0);
    chk("single_wstrb", last_wstrb, 32'hffff_ffff);
    chk("single_mem_11f", mem[16'h11f], 8'h1f);

    run_copy(64'h0, 64'h800, 32'd1000, 20);
    chk("tail_ar_count", ar_obs.size(), 2);
    chk("tail_arlen", {ar_obs[0].len, ar_obs[1].len}, 16'h0f0f);
    chk("tail_wstrb", last_wstrb, 32'h0000_00ff);
    chk("tail_mem_last", mem[16'h800 + 999], 8'he7);
    chk("tail_mem_untouched", mem[16'h800 + 1000], 8'h5a);

    run_copy(64'hf80, 64'h2000, 32'd256, 0);
`ifdef NPU_DMA_4K_SPLIT_EN
    chk("split_ar_count", ar_obs.size(), 2);
    chk("split_second_araddr", ar_obs[1].addr, 64'h1000);
    chk("split_arlen", {ar_obs[0].len, ar_obs[1].len}, 16'h0303);
`else
    chk("nosplit_ar_count", ar_obs.size(), 1);
    chk("nosplit_arlen", ar_obs[0].len, 8'd7);
`endif

    v0 = valid_seen;
    run_copy(64'h0, 64'h100, 32'd0, 0);
    chk("zero_no_valids", valid_seen - v0, 0);
    chk("zero_done_latency", done_cyc - acc_cyc, 1);

    bp = 1'b1;
    run_copy(64'h400, 64'h600, 32'd64, 0);
    run_copy(64'h1000, 64'h3000, 32'd200, 0);
    bp = 1'b0;

    d0 = done_cnt;
    issue(64'h0, 64'h400, 32'd512, 0);
    n = 0;
    while (!axi.m_axi_wvalid && n < 500) begin @(negedge clk); n++; end
    chk("reach_w_timeout", axi.m_axi_wvalid, 1'b1);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    ar_exp.delete(); aw_exp.delete(); w_exp.delete();
    #2 rst_n = 1'b1;
    #1 chk("ready_low_after_release", dma_req_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_midreset", {dma_req_ready, busy}, 2'b10);
    repeat (5) @(negedge clk);
    chk("no_done_after_midreset", done_cnt - d0, 0);
    run_copy(64'h200, 64'h300, 32'd32, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
